// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encodings for the universal shift register
package usr_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit with a hold/right/left/load mux and synchronous reset
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       from_hi,
    input  logic       from_lo,
    input  logic       load,
    output logic       q
);
    logic d;

    // Select the next value: hold, neighbour above (shift right), neighbour below (shift left) or load
    always_comb
        d = (sel == MODE_SHR)  ? from_hi :
            (sel == MODE_SHL)  ? from_lo :
            (sel == MODE_LOAD) ? load    : q;

    // Storage bit; reset wins over any selected operation
    always_ff @(posedge clk)
        if (!rst_n) q <= RESET_BIT;
        else        q <= d;
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold / shift right / shift left / parallel load register with optional rotate
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] lo_in;

    // Disabled register behaves exactly like hold, whatever the mode
    always_comb sel = en ? mode : MODE_HOLD;

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // End cells take the serial input, or the wrapped bit from the opposite end when rotating
        if (i == WIDTH - 1) begin : g_top
            assign hi_in[i] = rot ? q[0] : sin_r;
        end else begin : g_mid_hi
            assign hi_in[i] = q[i+1];
        end
        if (i == 0) begin : g_bot
            assign lo_in[i] = rot ? q[WIDTH-1] : sin_l;
        end else begin : g_mid_lo
            assign lo_in[i] = q[i-1];
        end
        usr_bit_cell #(.RESET_BIT(RESET_VAL[i])) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel    (sel),
            .from_hi(hi_in[i]),
            .from_lo(lo_in[i]),
            .load   (pdata[i]),
            .q      (q[i])
        );
    end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed scenarios plus randomized run against an arithmetic reference model
module tb_universal_shift_reg;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 0;
    logic       rst_n = 1, en = 0, rot = 0, sin_r = 0, sin_l = 0;
    logic [1:0] mode = 0;
    logic [7:0] pdata = 0;
    logic [7:0] q;
    logic       sout_r, sout_l;
    logic [7:0] model = 0;
    int         tests = 0, fails = 0;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .pdata(pdata),
        .q(q), .sout_r(sout_r), .sout_l(sout_l)
    );

    always #5 clk = ~clk;

    // Reference next-state from the operation rules, using integer shifts
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic e,
                                              input logic [1:0] m, input logic ro,
                                              input logic sr, input logic sl);
        int v, inb;
        v = int'(cur);
        if (!e || m == 2'd0) return cur;
        if (m == 2'd3) return pdata;
        if (m == 2'd1) begin
            inb = ro ? (v % 2) : int'(sr);
            return 8'((v / 2) + inb * 128);
        end
        inb = ro ? (v / 128) : int'(sl);
        return 8'(((v * 2) % 256) + inb);
    endfunction

    task automatic step(input logic r, input logic e, input logic [1:0] m, input logic ro,
                        input logic sr, input logic sl, input logic [7:0] pd);
        rst_n = r; en = e; mode = m; rot = ro; sin_r = sr; sin_l = sl; pdata = pd;
        @(posedge clk);
        #1;
        model = !r ? RV : model_next(model, e, m, ro, sr, sl);
    endtask

    task automatic test_reset;
        step(0, 1, 2'd3, 0, 0, 0, 8'h00);
        tests++;
        if (q !== 8'hA5) begin fails++; $display("FAIL reset_q: got %h want a5", q); end
        tests++;
        if (sout_r !== 1'b1 || sout_l !== 1'b1) begin
            fails++; $display("FAIL reset_taps: got r=%b l=%b want 1 1", sout_r, sout_l);
        end
    endtask

    task automatic test_shift_right;
        step(1, 1, 2'd3, 0, 0, 0, 8'h81);
        tests++;
        if (q !== 8'h81) begin fails++; $display("FAIL shr_load: got %h want 81", q); end
        step(1, 1, 2'd1, 0, 0, 1, 8'h00);
        tests++;
        if (q !== 8'h40) begin fails++; $display("FAIL shr_1: got %h want 40", q); end
        step(1, 1, 2'd1, 0, 0, 1, 8'h00);
        tests++;
        if (q !== 8'h20) begin fails++; $display("FAIL shr_2: got %h want 20", q); end
        step(1, 1, 2'd1, 0, 1, 0, 8'h00);
        tests++;
        if (q !== 8'h90 || sout_l !== 1'b1 || sout_r !== 1'b0) begin
            fails++; $display("FAIL shr_sin1: got %h l=%b r=%b want 90 1 0", q, sout_l, sout_r);
        end
    endtask

    task automatic test_rotate;
        step(1, 1, 2'd3, 1, 0, 0, 8'h81);
        step(1, 1, 2'd2, 1, 0, 0, 8'h00);
        tests++;
        if (q !== 8'h03) begin fails++; $display("FAIL rotl_1: got %h want 03", q); end
        for (int i = 0; i < 7; i++) step(1, 1, 2'd2, 1, 0, 0, 8'h00);
        tests++;
        if (q !== 8'h81) begin fails++; $display("FAIL rotl_8: got %h want 81", q); end
        step(1, 1, 2'd3, 0, 0, 0, 8'h6B);
        step(1, 1, 2'd1, 1, 0, 0, 8'h00);
        tests++;
        if (q !== 8'hB5) begin fails++; $display("FAIL rotr_1: got %h want b5", q); end
        for (int i = 0; i < 7; i++) step(1, 1, 2'd1, 1, 0, 0, 8'h00);
        tests++;
        if (q !== 8'h6B) begin fails++; $display("FAIL rotr_8: got %h want 6b", q); end
    endtask

    task automatic test_enable;
        step(1, 1, 2'd3, 0, 0, 0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'd3, 0, 0, 0, 8'hFF);
            tests++;
            if (q !== 8'h3C) begin fails++; $display("FAIL en_hold_%0d: got %h want 3c", i, q); end
        end
        for (int m = 1; m < 3; m++) begin
            step(1, 0, 2'(m), 1'(m - 1), 1, 1, 8'hFF);
            tests++;
            if (q !== 8'h3C) begin fails++; $display("FAIL en_shift_%0d: got %h want 3c", m, q); end
        end
        step(1, 1, 2'd3, 0, 0, 0, 8'hFF);
        tests++;
        if (q !== 8'hFF) begin fails++; $display("FAIL en_load: got %h want ff", q); end
    endtask

    task automatic test_reset_priority;
        step(0, 1, 2'd3, 0, 0, 0, 8'h55);
        tests++;
        if (q !== 8'hA5) begin fails++; $display("FAIL rst_prio: got %h want a5", q); end
        step(1, 1, 2'd3, 0, 0, 0, 8'h55);
        tests++;
        if (q !== 8'h55) begin fails++; $display("FAIL rst_release: got %h want 55", q); end
        step(1, 1, 2'd2, 0, 0, 1, 8'h00);
        step(0, 1, 2'd2, 0, 0, 1, 8'h00);
        step(1, 1, 2'd1, 0, 1, 0, 8'h00);
        tests++;
        if (q !== 8'hD2) begin fails++; $display("FAIL rst_mid: got %h want d2", q); end
    endtask

    task automatic test_serial_fill;
        logic [3:0] pat;
        pat = 4'b1011;
        step(1, 1, 2'd3, 0, 0, 0, 8'h00);
        for (int i = 3; i >= 0; i--) step(1, 1, 2'd2, 0, 1, pat[i], 8'h00);
        tests++;
        if (q !== 8'h0B) begin fails++; $display("FAIL serial_fill: got %h want 0b", q); end
        step(1, 1, 2'd0, 1, 1, 1, 8'hFF);
        tests++;
        if (q !== 8'h0B) begin fails++; $display("FAIL hold_mode: got %h want 0b", q); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            tests++;
            if (q !== model || sout_r !== model[0] || sout_l !== model[7]) begin
                fails++;
                $display("FAIL random_%0d: got q=%h r=%b l=%b want %h %b %b",
                         i, q, sout_r, sout_l, model, model[0], model[7]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_shift_right;
        test_rotate;
        test_enable;
        test_reset_priority;
        test_serial_fill;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
